// File: rtl/tick_period_meter.sv
// tick_period_meter
// Measures the distance in clk cycles between consecutive rising edges of
// tick_in. Each completed period is reported with a one-cycle strobe. The
// block also flags a gap that is too long to count (overflow), and flags a
// stable stream (locked: the last two periods were equal).
module tick_period_meter #(
  parameter int WIDTH = 16,
  parameter bit SYNC  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             locked
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] last;
  logic             last_valid;
  logic             s;
  logic             prev;
  logic             tick_edge;

  // Input sampling: either tick_in as-is, or through a two-flop synchronizer
  // when the pulse source lives in another clock domain.
  if (SYNC) begin : g_sync
    logic [1:0] sync_q;

    // Two-stage synchronizer shift register, cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples the pre-edge values of the others, which is what the hardware does.
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[0], tick_in};
    end

    assign s = sync_q[1];
  end else begin : g_direct
    assign s = tick_in;
  end

  // Previous sample of s. It keeps running in every state, so an input that is
  // already high when enable rises is not mistaken for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= 1'b0;
    else     prev <= s;
  end

  // A held-high input produces exactly one edge.
  assign tick_edge = s & ~prev;

  // Measurement FSM. The counter, last-period tracking and all outputs are
  // registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      last         <= '0;
      last_valid   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      locked       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      overflow     <= 1'b0;
      if (!enable) begin
        // Disabling drops everything except the last reported period, and it
        // wins over any edge seen in the same cycle.
        state      <= IDLE;
        counter    <= '0;
        locked     <= 1'b0;
        last_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= ARMED;
            counter    <= '0;
            last_valid <= 1'b0;
          end
          ARMED: begin
            last_valid <= 1'b0;
            if (tick_edge) begin
              counter <= CNT_ONE;
              state   <= MEASURE;
            end
          end
          MEASURE: begin
            if (tick_edge) begin
              // An edge beats the overflow check: a gap of exactly CNT_MAX is
              // still a valid period.
              period       <= counter;
              period_valid <= 1'b1;
              locked       <= last_valid && (counter == last);
              last         <= counter;
              last_valid   <= 1'b1;
              counter      <= CNT_ONE;
            end else if (counter == CNT_MAX) begin
              // The counter saturates here and never wraps. Re-arm and wait
              // for a fresh first edge.
              overflow   <= 1'b1;
              locked     <= 1'b0;
              last_valid <= 1'b0;
              counter    <= '0;
              state      <= ARMED;
            end else begin
              counter <= counter + CNT_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            counter <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Self-checking bench for tick_period_meter. Three instances share the same
// stimulus: WIDTH=16, WIDTH=4 (overflow boundary) and WIDTH=16 with SYNC=1.
// A cycle-level reference model works from edge times. It pushes the expected
// period/overflow events into per-instance queues, and a monitor pops and
// compares them whenever an instance strobes.
module tb_tick_period_meter;

  typedef struct {
    bit is_ovf;
    int per;
    bit lk;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tick_in = 1'b0;

  logic [15:0] per_a [3];
  logic        pv_a  [3];
  logic        ov_a  [3];
  logic        lk_a  [3];
  logic [3:0]  per4;

  int errors = 0;
  int checks = 0;

  // Reference model state
  ev_t exp_q [3][$];
  int  max_cnt [3] = '{65535, 15, 65535};
  int  delay   [3] = '{0, 0, 2};
  bit  th[$];
  bit  en_prev = 1'b0;
  int  cyc = 0;
  bit  ref_valid [3];
  int  ref_cyc   [3];
  bit  last_valid[3];
  int  last_per  [3];
  int  exp_period[3];
  bit  exp_locked[3];

  always #5 clk = ~clk;

  tick_period_meter #(.WIDTH(16), .SYNC(1'b0)) dut16 (
    .clk(clk), .rst(rst), .enable(enable), .tick_in(tick_in),
    .period(per_a[0]), .period_valid(pv_a[0]), .overflow(ov_a[0]), .locked(lk_a[0]));

  tick_period_meter #(.WIDTH(4), .SYNC(1'b0)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .tick_in(tick_in),
    .period(per4), .period_valid(pv_a[1]), .overflow(ov_a[1]), .locked(lk_a[1]));

  tick_period_meter #(.WIDTH(16), .SYNC(1'b1)) dut16s (
    .clk(clk), .rst(rst), .enable(enable), .tick_in(tick_in),
    .period(per_a[2]), .period_valid(pv_a[2]), .overflow(ov_a[2]), .locked(lk_a[2]));

  assign per_a[1] = {12'd0, per4};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Sampled input as seen by an instance with the given input latency.
  function automatic bit samp(input int d);
    if (th.size() > d) return th[th.size() - 1 - d];
    return 1'b0;
  endfunction

  // Reference model: one step per clock edge, reasoning about edge times.
  always @(posedge clk) begin
    if (rst) begin
      th.delete();
      en_prev = 1'b0;
      for (int i = 0; i < 3; i++) begin
        ref_valid[i]  = 1'b0;
        last_valid[i] = 1'b0;
        exp_locked[i] = 1'b0;
        exp_period[i] = 0;
      end
    end else begin
      th.push_back(tick_in);
      if (th.size() > 4) void'(th.pop_front());
      for (int i = 0; i < 3; i++) begin
        bit e;
        bit armed;
        e     = samp(delay[i]) & ~samp(delay[i] + 1);
        armed = enable && en_prev;
        if (!armed) begin
          ref_valid[i]  = 1'b0;
          last_valid[i] = 1'b0;
          if (!enable) exp_locked[i] = 1'b0;
        end else if (e) begin
          if (ref_valid[i]) begin
            ev_t ev;
            int  gap;
            gap       = cyc - ref_cyc[i];
            ev.is_ovf = 1'b0;
            ev.per    = gap;
            ev.lk     = last_valid[i] && (gap == last_per[i]);
            exp_q[i].push_back(ev);
            exp_period[i] = gap;
            exp_locked[i] = ev.lk;
            last_per[i]   = gap;
            last_valid[i] = 1'b1;
          end
          ref_cyc[i]   = cyc;
          ref_valid[i] = 1'b1;
        end else if (ref_valid[i] && (cyc - ref_cyc[i] == max_cnt[i])) begin
          ev_t ev;
          ev.is_ovf = 1'b1;
          ev.per    = exp_period[i];
          ev.lk     = 1'b0;
          exp_q[i].push_back(ev);
          exp_locked[i] = 1'b0;
          ref_valid[i]  = 1'b0;
          last_valid[i] = 1'b0;
        end
      end
      en_prev = enable;
      cyc++;
    end
  end

  // Monitor: on every strobe, pop the next expected event and compare.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (pv_a[i] || ov_a[i]) begin
          check($sformatf("dut%0d valid_and_overflow_together", i), int'(pv_a[i] & ov_a[i]), 0);
          if (exp_q[i].size() == 0) begin
            check($sformatf("dut%0d unexpected_strobe(pv=%0d ov=%0d per=%0d)", i, pv_a[i], ov_a[i],
                            per_a[i]), 1, 0);
          end else begin
            ev_t ev;
            ev = exp_q[i].pop_front();
            check($sformatf("dut%0d overflow_strobe", i), int'(ov_a[i]), int'(ev.is_ovf));
            check($sformatf("dut%0d period_valid_strobe", i), int'(pv_a[i]), int'(!ev.is_ovf));
            check($sformatf("dut%0d locked", i), int'(lk_a[i]), int'(ev.lk));
            if (!ev.is_ovf) check($sformatf("dut%0d period", i), int'(per_a[i]), ev.per);
          end
        end
      end
    end
  end

  task automatic drive(input bit v, input bit en);
    @(posedge clk);
    #1;
    tick_in = v;
    enable  = en;
  endtask

  // One pulse period: w cycles high followed by gap-w cycles low.
  task automatic pulse(input int gap, input int w);
    for (int k = 0; k < gap; k++) drive(k < w, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s dut%0d period", tag, i), int'(per_a[i]), 0);
      check($sformatf("%s dut%0d period_valid", tag, i), int'(pv_a[i]), 0);
      check($sformatf("%s dut%0d overflow", tag, i), int'(ov_a[i]), 0);
      check($sformatf("%s dut%0d locked", tag, i), int'(lk_a[i]), 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);

    // Divider tick every 16 cycles (one cycle high)
    repeat (6) pulse(16, 1);
    check("div16 locked level", int'(lk_a[0]), 1);

    // Alternating 0/1, then period 5
    repeat (12) pulse(2, 1);
    repeat (5) pulse(5, 2);

    // Gaps of 20 (overflow on the WIDTH=4 instance), then exactly 15
    repeat (4) pulse(20, 1);
    repeat (4) pulse(15, 1);

    // Long high runs: one edge per run
    repeat (4) pulse(30, 10);

    // Randomized gaps and widths
    for (int n = 0; n < 25; n++) begin
      int gap;
      gap = $urandom_range(40, 2);
      pulse(gap, $urandom_range(gap - 1, 1));
    end

    // Drop enable mid-measurement with an edge in the same cycle
    repeat (5) pulse(16, 1);
    repeat (7) drive(1'b0, 1'b1);
    drive(1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("disable dut%0d locked", i), int'(lk_a[i]), 0);
      check($sformatf("disable dut%0d period_held", i), int'(per_a[i]), exp_period[i]);
    end
    check("disable dut0 period_is_16", int'(per_a[0]), 16);
    repeat (3) drive(1'b1, 1'b0);
    repeat (4) drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    repeat (4) pulse(12, 3);

    // Asynchronous reset while locked on period 16
    repeat (4) pulse(16, 1);
    @(negedge clk);
    check("pre_reset dut0 locked", int'(lk_a[0]), 1);
    check("pre_reset dut0 period", int'(per_a[0]), 16);
    check("pre_reset dut2 locked", int'(lk_a[2]), 1);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) exp_q[i].delete();
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) pulse(7, 1);

    repeat (20) drive(1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("dut%0d missing_events", i), exp_q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the spacing, in `clk` cycles, between consecutive rising edges of a tick or pulse input. It reports each measured period with a one-cycle valid strobe and flags when the stream is stable (locked) or too slow (overflow). It sits downstream of the counter/divider tick generators, where it checks divider ratios and timebase ticks in hardware and on the bench.

## Interface
Parameters:
- `WIDTH`, default 16: width of the period counter and the `period` output; maximum measurable period is 2^WIDTH-1 cycles.
- `SYNC`, default 0: 0 samples `tick_in` directly (same clock domain); 1 inserts a two-flop synchronizer ahead of edge detection.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset: asynchronous, active-high.
- `enable`  in  1  measurement enable, level-sensitive.
- `tick_in`  in  1  pulse stream to measure.
- `period`  out  WIDTH  last completed period in clk cycles.
- `period_valid`  out  1  one-cycle strobe; `period` is updated in the same cycle.
- `overflow`  out  1  one-cycle strobe; gap exceeded 2^WIDTH-1 cycles.
- `locked`  out  1  level; the last two completed periods were equal.

## Operation
- Sampled input `s`: `tick_in` when SYNC=0, or the output of the two-flop synchronizer when SYNC=1.
- `prev` register holds `s` from the previous cycle.
- `edge = s & ~prev`. A held-high input produces exactly one edge.
- States:
  - IDLE: counter = 0. Next state is ARMED when `enable`=1.
  - ARMED: waits for the first edge. On `edge`: counter <= 1 and go to MEASURE.
  - MEASURE: each cycle without an edge, counter <= counter+1.
    - On `edge`: `period` <= counter, `period_valid` <= 1, counter <= 1, stay in MEASURE.
    - If counter = 2^WIDTH-1 and there is no edge: `overflow` <= 1, `locked` <= 0, go to ARMED. No `period_valid`.
- Lock:
  - A register `last` holds the previous completed period.
  - On each completed measurement: `locked` <= (counter == `last`) and `last` <= counter.
  - `last` is invalidated on entry to ARMED or IDLE, so the first period after arming never asserts `locked`.
- `enable`=0 in any state:
  - Next state is IDLE, counter = 0, `locked` <= 0, `last` is invalidated.
  - `period` holds its value.
  - An edge in the same cycle is ignored.
- `prev` keeps updating in all states, including IDLE. An input already high when `enable` rises does not count as an edge.
- Counter arithmetic: unsigned WIDTH bits, never wraps. The overflow check precedes the increment.

## Timing
- Reset values: `period`=0, `period_valid`=0, `overflow`=0, `locked`=0; state IDLE; counter=0; `prev`=0; `last` invalid; synchronizer flops 0.
- An edge detected in cycle t produces `period`/`period_valid` visible in cycle t+1. SYNC=1 adds 2 cycles of input latency, and the measured values are unchanged.
- Edges in cycles t0 and t0+P yield `period`=P, for 2 ≤ P ≤ 2^WIDTH-1. P=1 is impossible because an edge needs a low sample between highs.
- Overflow strobe: in the cycle after the counter sat at 2^WIDTH-1 with no edge. An edge in that same cycle wins: it is a valid period of 2^WIDTH-1, with no overflow.
- `period_valid` and `overflow` are never high together. Each is high for exactly one cycle per event.
- Asynchronous reset mid-measurement: all outputs clear immediately, without waiting for a clock edge. After release the block starts in IDLE.

## Test plan
- Counter divider tick, BITS=4 (tick one cycle every 16), WIDTH=16, `enable`=1:
  - No `period_valid` after the first edge.
  - `period`=16 with `period_valid` one cycle after the second edge.
  - `locked`=1 after the third edge and stays high.
- Alternating tick_in 0/1 every cycle: `period`=2 on every valid. Then switch to period 5: one valid of 5 with `locked`=0, then `locked`=1 on the next.
- WIDTH=4, edges 20 cycles apart: `overflow` strobes 15 cycles after the first counted cycle. No `period_valid`. The next edge re-arms. Edges exactly 15 apart give `period`=15 and no overflow.
- tick_in held high for 10 cycles, then low, repeating every 30 cycles: `period`=30 (one edge per high run).
- Drop `enable` mid-measurement, with an edge in the same cycle:
  - Returns to IDLE and `locked`=0.
  - `period` keeps its prior value.
  - Re-enable with tick_in high: no edge counted until the next 0→1 transition.
- Assert `rst` asynchronously between clock edges while `locked`=1 and `period`=16: all outputs read 0 before the next `clk` edge. Repeat the scenarios with SYNC=1 and check identical periods, shifted by 2 cycles.
